// File: rtl/ili9341_window_streamer_if.sv
// Shared SPI transaction type and the bundled request / pixel / SPI-word
// interface of the ILI9341 window streamer.
package ili9341_pkg;
  typedef enum logic [1:0] {
    WRITE_8  = 2'd0,
    WRITE_16 = 2'd1,
    READ_8   = 2'd2,
    READ_16  = 2'd3
  } spi_transaction_t;
endpackage

interface ili9341_window_streamer_if;
  import ili9341_pkg::*;

  // window request
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_x0;
  logic [15:0]      req_x1;
  logic [15:0]      req_y0;
  logic [15:0]      req_y1;
  logic             req_err;
  // pixel stream
  logic             px_valid;
  logic [15:0]      px_data;
  logic             px_ready;
  logic             abort;
  // spi_controller word interface
  logic             spi_valid;
  logic             spi_ready;
  logic [15:0]      spi_data;
  spi_transaction_t spi_mode;
  logic             data_commandb;
  // status pulses
  logic             row_end;
  logic             frame_end;
  logic             done;
  logic             aborted;

  // streamer side
  modport master (
    input  req_valid, req_x0, req_x1, req_y0, req_y1,
    input  px_valid, px_data, abort, spi_ready,
    output req_ready, req_err, px_ready,
    output spi_valid, spi_data, spi_mode, data_commandb,
    output row_end, frame_end, done, aborted
  );

  // pixel source / spi_controller side
  modport slave (
    output req_valid, req_x0, req_x1, req_y0, req_y1,
    output px_valid, px_data, abort, spi_ready,
    input  req_ready, req_err, px_ready,
    input  spi_valid, spi_data, spi_mode, data_commandb,
    input  row_end, frame_end, done, aborted
  );
endinterface

// File: rtl/ili9341_window_streamer.sv
// ILI9341 window streamer: takes a clipped draw window, sends the
// CASET/PASET/RAMWR header as WRITE_8 words, then forwards RGB565 pixels as
// WRITE_16 words with valid/ready backpressure until the window is full.
module ili9341_window_streamer
  import ili9341_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int CNT_W          = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  ili9341_window_streamer_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] X_MAX   = 16'(DISPLAY_WIDTH - 1);
  localparam logic [15:0] Y_MAX   = 16'(DISPLAY_HEIGHT - 1);
  localparam logic [3:0]  HDR_END = 4'd10;

  state_t           state;
  logic [3:0]       idx;
  logic [15:0]      x0;
  logic [15:0]      x1;
  logic [15:0]      y0;
  logic [15:0]      y1;
  logic [15:0]      col;
  logic [CNT_W-1:0] npix;
  logic [CNT_W-1:0] remaining;
  logic             req_err_q;
  logic             aborted_q;

  logic [15:0]      req_x1c;
  logic [15:0]      req_y1c;
  logic             req_bad;
  logic [CNT_W-1:0] span_w;
  logic [CNT_W-1:0] span_h;
  logic [CNT_W-1:0] req_npix;
  logic [7:0]       hdr_byte;
  logic             hdr_dc;
  logic             hdr_xfer;
  logic             pix_xfer;

  // Clamp the incoming request to the panel and size the clipped window.
  always_comb begin
    req_x1c  = (bus.req_x1 > X_MAX) ? X_MAX : bus.req_x1;
    req_y1c  = (bus.req_y1 > Y_MAX) ? Y_MAX : bus.req_y1;
    req_bad  = (bus.req_x0 > req_x1c) || (bus.req_y0 > req_y1c);
    span_w   = CNT_W'(req_x1c - bus.req_x0) + CNT_W'(1);
    span_h   = CNT_W'(req_y1c - bus.req_y0) + CNT_W'(1);
    req_npix = span_w * span_h;
  end

  // Header word for the current index: command bytes carry dc=0.
  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (idx)
      4'd0:    begin hdr_byte = 8'h2A; hdr_dc = 1'b0; end
      4'd1:    hdr_byte = x0[15:8];
      4'd2:    hdr_byte = x0[7:0];
      4'd3:    hdr_byte = x1[15:8];
      4'd4:    hdr_byte = x1[7:0];
      4'd5:    begin hdr_byte = 8'h2B; hdr_dc = 1'b0; end
      4'd6:    hdr_byte = y0[15:8];
      4'd7:    hdr_byte = y0[7:0];
      4'd8:    hdr_byte = y1[15:8];
      4'd9:    hdr_byte = y1[7:0];
      4'd10:   begin hdr_byte = 8'h2C; hdr_dc = 1'b0; end
      default: begin hdr_byte = 8'h00; hdr_dc = 1'b1; end
    endcase
  end

  // Word-transfer qualifiers for each phase.
  always_comb begin
    hdr_xfer = (state == S_HDR) && bus.spi_ready && ena;
    pix_xfer = (state == S_PIX) && bus.px_valid && bus.spi_ready && ena;
  end

  // SPI word outputs; the pixel path is a zero-latency pass-through.
  always_comb begin
    bus.spi_valid     = 1'b0;
    bus.spi_data      = 16'h0000;
    bus.spi_mode      = WRITE_8;
    bus.data_commandb = 1'b1;
    bus.px_ready      = 1'b0;
    bus.row_end       = 1'b0;
    bus.frame_end     = 1'b0;
    case (state)
      S_HDR: begin
        bus.spi_valid     = ena;
        bus.spi_data      = {8'h00, hdr_byte};
        bus.data_commandb = hdr_dc;
      end
      S_PIX: begin
        bus.spi_valid     = bus.px_valid && ena;
        bus.spi_data      = bus.px_data;
        bus.spi_mode      = WRITE_16;
        bus.px_ready      = bus.spi_ready && ena;
        bus.row_end       = pix_xfer && (col == x1);
        bus.frame_end     = pix_xfer && (remaining == CNT_W'(1));
      end
      default: begin
        bus.spi_valid = 1'b0;
      end
    endcase
  end

  // Handshake and status outputs decoded from registered state.
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.done      = (state == S_DONE) && ena;
    bus.req_err   = req_err_q;
    bus.aborted   = aborted_q;
  end

  // Window FSM: request latch, header sequencing, pixel counting, abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      x0        <= 16'd0;
      x1        <= 16'd0;
      y0        <= 16'd0;
      y1        <= 16'd0;
      col       <= 16'd0;
      npix      <= '0;
      remaining <= '0;
      req_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      aborted_q <= 1'b0;
      if (ena) begin
        case (state)
          S_IDLE: begin
            if (bus.req_valid) begin
              if (req_bad) begin
                req_err_q <= 1'b1;
              end else begin
                x0    <= bus.req_x0;
                x1    <= req_x1c;
                y0    <= bus.req_y0;
                y1    <= req_y1c;
                npix  <= req_npix;
                idx   <= 4'd0;
                state <= S_HDR;
              end
            end
          end
          S_HDR: begin
            if (bus.abort) begin
              state     <= S_IDLE;
              aborted_q <= 1'b1;
            end else if (hdr_xfer) begin
              if (idx == HDR_END) begin
                state     <= S_PIX;
                col       <= x0;
                remaining <= npix;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
          S_PIX: begin
            if (pix_xfer) begin
              col       <= (col == x1) ? x0 : col + 16'd1;
              remaining <= remaining - CNT_W'(1);
            end
            if (bus.abort) begin
              state     <= S_IDLE;
              aborted_q <= 1'b1;
            end else if (pix_xfer && (remaining == CNT_W'(1))) begin
              state <= S_DONE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ili9341_window_streamer.md
Name: ili9341_window_streamer

Overview:
- Streaming successor to the fixed full-screen test-pattern display controller.
- Accepts a rectangular draw window request, issues CASET/PASET/RAMWR over the existing spi_controller word interface, then streams caller-supplied RGB565 pixels into that window with valid/ready backpressure.
- Display geometry is parametrised; the window is clipped to the panel, and the transfer can be aborted.
- Sits between pixel sources (sprite/etch-a-sketch logic) and spi_controller, after the init-ROM sequencer has finished.

Parameters:
- DISPLAY_WIDTH, 240, panel columns; x coordinates are clipped to DISPLAY_WIDTH-1.
- DISPLAY_HEIGHT, 320, panel rows; y coordinates are clipped to DISPLAY_HEIGHT-1.
- CNT_W, $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)+1, width of the internal pixel counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; when low, the FSM is frozen, and spi_valid and px_ready are forced to 0.
- req_valid  in  1  window request valid.
- req_ready  out  1  high only in S_IDLE.
- req_x0, req_x1, req_y0, req_y1  in  16 each  inclusive window corners.
- req_err  out  1  one-cycle pulse when a request is rejected.
- px_valid  in  1  pixel valid.
- px_data  in  16  RGB565 pixel.
- px_ready  out  1  pixel accepted when px_valid & px_ready.
- abort  in  1  cancel the active window.
- spi_valid  out  1  to spi_controller i_valid.
- spi_ready  in  1  from spi_controller i_ready.
- spi_data  out  16  to i_data; bytes are in [7:0] with [15:8]=0.
- spi_mode  out  spi_transaction_t  WRITE_8 for cmd/param, WRITE_16 for pixels.
- data_commandb  out  1  0 = command byte, 1 = data.
- row_end  out  1  pulse on the last pixel of a window row.
- frame_end  out  1  pulse on the last pixel of the window.
- done  out  1  one-cycle pulse on completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async): state=S_IDLE, all counters=0, spi_valid=0, data_commandb=1, spi_mode=WRITE_8, spi_data=0. All pulse outputs and px_ready are 0.
- SPI word transfer rule: a word transfers on a cycle with spi_valid & spi_ready & ena. spi_data, spi_mode and data_commandb are held stable while spi_valid=1 without ready.
- S_IDLE:
  - On req_valid & ena, clamp x1 to min(req_x1, W-1) and y1 to min(req_y1, H-1).
  - If req_x0 > x1c or req_y0 > y1c: pulse req_err next cycle and stay in S_IDLE.
  - Otherwise latch x0, x1c, y0, y1c, and npix = (x1c-x0+1)*(y1c-y0+1); go to S_HDR with idx=0.
- S_HDR: 11-word WRITE_8 header, one word per transfer, idx 0..10:
  - 0x2A (dc=0), x0[15:8], x0[7:0], x1c[15:8], x1c[7:0] (dc=1)
  - 0x2B (dc=0), y0 hi, y0 lo, y1c hi, y1c lo (dc=1)
  - 0x2C (dc=0)
  - After idx 10 transfers, go to S_PIX with col=x0, remaining=npix.
- S_PIX:
  - spi_mode=WRITE_16, dc=1, spi_valid=px_valid, spi_data=px_data, px_ready=spi_ready&ena. All of these are combinational, so the path adds zero latency.
  - Per accepted pixel: col increments. When col==x1c, row_end pulses in the same cycle and col wraps to x0.
  - On the last pixel (remaining==1): frame_end pulses in the same cycle, next state is S_DONE.
- S_DONE: done=1 for one cycle, then S_IDLE. The earliest next request is accepted the cycle after.
- abort:
  - Effective in S_HDR or S_PIX. If abort coincides with a transfer, that transfer completes.
  - Next state is S_IDLE, aborted pulses for one cycle, done is not pulsed.
  - A partially sent header byte is never retracted; spi_controller finishes it.
  - abort in S_IDLE or S_DONE is ignored.
- Requests arriving outside S_IDLE are not accepted (req_ready=0).
- Reset mid-operation returns to S_IDLE immediately with no pulses.
- ena low freezes all state, counters and held outputs; there are no pulses while ena=0.

Test Plan:
- Full screen: req (0,239,0,319), px_valid tied 1, spi_ready always 1.
  - Header bytes 2A,00,00,00,EF,2B,00,00,01,3F,2C with dc 0,1,1,1,1,0,1,1,1,1,0.
  - Then 76800 WRITE_16 words; row_end 320 times, frame_end once, done one cycle after the last pixel.
- Clipping: req (200,300,310,400) -> header x1=00EF, y1=013F; npix = 40*10 = 400; row_end every 40 pixels.
- Reject: req (50,10,0,0) -> req_err pulses once, no spi_valid, req_ready stays 1.
- Backpressure: spi_ready toggling 1-0-1 and px_valid random over a 3x2 window at (5,7) -> exactly 6 pixels transfer in order, and spi_data/dc stay stable while stalled.
- Abort: abort asserted during the 3rd pixel of a 4x4 window -> aborted pulses, no done or frame_end, next request accepted.
- Async reset asserted during header idx 4 -> outputs return to reset values without a clock edge, and the FSM is in S_IDLE.
